img_sram_arbiter: RTL and testbench

Slave-side responder for the image SRAM port. It presents the slave end of img_sram_intf to two masters, client 0 (io_rx_controller) and client 1 (io_tx_controller), and drives one img_sram_intf master port into img_sram_4_64. It grants the SRAM to one client at a time, inserts hold-state turnaround cycles between owners, and routes read data back to the client that issued the read.

---
 rtl/img_sram_arb_pkg.sv | 48 ++++
 rtl/img_sram_owner_pipe.sv | 46 ++++
 rtl/img_sram_arbiter.sv | 142 ++++++++++++++
 tb/tb_img_sram_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : img_sram_arb_pkg
// Brief    : Shared types, widths and hold-state values for the image SRAM
//            arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package img_sram_arb_pkg;

  localparam int DATA_W = 8;
  localparam int ROW_W  = 2;
  localparam int COL_W  = 6;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_C0   = 2'd1,
    OWN_C1   = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    TURN = 2'd3
  } arb_state_e;

  localparam logic [DATA_W-1:0] HOLD_DIN = '0;
  localparam logic [ROW_W-1:0]  HOLD_ROW = '0;
  localparam logic [COL_W-1:0]  HOLD_COL = '0;
  localparam logic              HOLD_WE  = 1'b0;
  localparam logic              HOLD_SE  = 1'b1;

  // Round-robin pick from a non-owning state; a tie goes to the client
  // that did not own the SRAM last.
  function automatic arb_state_e arb_pick(input logic [1:0] req,
                                          input logic       last_owner);
    arb_state_e nxt;
    case (req)
      2'b01:   nxt = OWN0;
      2'b10:   nxt = OWN1;
      2'b11:   nxt = last_owner ? OWN0 : OWN1;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/img_sram_owner_pipe.sv
`default_nettype none
// ============================================================================
// Module   : img_sram_owner_pipe
// Brief    : Tracks which client issued each SRAM access and steers the
//            returning dout to that client DOUT_LAT cycles later.
// Revision : 1.0 - initial release
// ============================================================================
module img_sram_owner_pipe
  import img_sram_arb_pkg::*;
#(
  parameter int DOUT_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        owner_in,
  input  logic [DATA_W-1:0] sram_dout,
  output logic [DATA_W-1:0] c0_dout,
  output logic [DATA_W-1:0] c1_dout,
  output logic              busy
);

  logic [1:0] r_pipe [DOUT_LAT];
  logic [1:0] w_tail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DOUT_LAT; i++) r_pipe[i] <= OWN_NONE;
    end else begin
      r_pipe[0] <= owner_in;
      for (int i = 1; i < DOUT_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DOUT_LAT; i++) begin
      if (r_pipe[i] != OWN_NONE) busy = 1'b1;
    end
  end

  assign w_tail  = r_pipe[DOUT_LAT-1];
  assign c0_dout = (w_tail == OWN_C0) ? sram_dout : {DATA_W{1'b0}};
  assign c1_dout = (w_tail == OWN_C1) ? sram_dout : {DATA_W{1'b0}};

endmodule
`default_nettype wire

// File: rtl/img_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : img_sram_arbiter
// Brief    : Two-client round-robin arbiter for the image SRAM port with
//            hold-state turnaround and owner-tagged read data routing.
// Revision : 1.0 - initial release
// ============================================================================
module img_sram_arbiter
  import img_sram_arb_pkg::*;
#(
  parameter int TURNAROUND = 1,
  parameter int DOUT_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  output logic [1:0]        gnt,
  output logic              busy,
  input  logic [DATA_W-1:0] c0_din,
  input  logic [ROW_W-1:0]  c0_row,
  input  logic [COL_W-1:0]  c0_col,
  input  logic              c0_write_en,
  input  logic              c0_sense_en,
  output logic [DATA_W-1:0] c0_dout,
  input  logic [DATA_W-1:0] c1_din,
  input  logic [ROW_W-1:0]  c1_row,
  input  logic [COL_W-1:0]  c1_col,
  input  logic              c1_write_en,
  input  logic              c1_sense_en,
  output logic [DATA_W-1:0] c1_dout,
  output logic [DATA_W-1:0] sram_din,
  output logic [ROW_W-1:0]  sram_row,
  output logic [COL_W-1:0]  sram_col,
  output logic              sram_write_en,
  output logic              sram_sense_en,
  input  logic [DATA_W-1:0] sram_dout
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_OWN0 = OWN0;
  localparam logic [1:0] S_OWN1 = OWN1;
  localparam logic [1:0] S_TURN = TURN;

  localparam logic [1:0] c_turn_load = (TURNAROUND > 0) ? 2'(TURNAROUND - 1) : 2'd0;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_last_owner;
  logic       w_last_nxt;
  logic [1:0] r_turn_cnt;
  logic [1:0] w_turn_nxt;
  logic [1:0] r_gnt;
  logic [1:0] w_owner;
  logic       w_pipe_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last_owner;
    w_turn_nxt  = r_turn_cnt;
    case (r_state)
      S_IDLE: w_state_nxt = arb_pick(req, r_last_owner);
      S_OWN0, S_OWN1: begin
        if (!req[r_state == S_OWN1]) begin
          w_last_nxt = (r_state == S_OWN1);
          if (!req[r_state == S_OWN0]) begin
            w_state_nxt = S_IDLE;
          end else if (TURNAROUND == 0) begin
            w_state_nxt = (r_state == S_OWN0) ? S_OWN1 : S_OWN0;
          end else begin
            w_state_nxt = S_TURN;
            w_turn_nxt  = c_turn_load;
          end
        end
      end
      S_TURN: begin
        // Requests may have changed while waiting, so arbitrate afresh on exit.
        if (r_turn_cnt == 2'd0) w_state_nxt = arb_pick(req, r_last_owner);
        else                    w_turn_nxt  = r_turn_cnt - 2'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_owner <= 1'b1;
      r_turn_cnt   <= 2'd0;
      r_gnt        <= 2'b00;
    end else begin
      r_state      <= w_state_nxt;
      r_last_owner <= w_last_nxt;
      r_turn_cnt   <= w_turn_nxt;
      r_gnt        <= {w_state_nxt == S_OWN1, w_state_nxt == S_OWN0};
    end
  end

  always_comb begin
    sram_din      = HOLD_DIN;
    sram_row      = HOLD_ROW;
    sram_col      = HOLD_COL;
    sram_write_en = HOLD_WE;
    sram_sense_en = HOLD_SE;
    w_owner       = OWN_NONE;
    case (r_state)
      S_OWN0: begin
        sram_din      = c0_din;
        sram_row      = c0_row;
        sram_col      = c0_col;
        sram_write_en = c0_write_en;
        sram_sense_en = c0_sense_en;
        w_owner       = OWN_C0;
      end
      S_OWN1: begin
        sram_din      = c1_din;
        sram_row      = c1_row;
        sram_col      = c1_col;
        sram_write_en = c1_write_en;
        sram_sense_en = c1_sense_en;
        w_owner       = OWN_C1;
      end
      default: ;
    endcase
  end

  img_sram_owner_pipe #(
    .DOUT_LAT (DOUT_LAT)
  ) u_owner_pipe (
    .clk       (clk),
    .rst       (rst),
    .owner_in  (w_owner),
    .sram_dout (sram_dout),
    .c0_dout   (c0_dout),
    .c1_dout   (c1_dout),
    .busy      (w_pipe_busy)
  );

  assign gnt  = r_gnt;
  assign busy = (r_state != S_IDLE) || w_pipe_busy;

endmodule
`default_nettype wire

// File: tb/tb_img_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_img_sram_arbiter
// Brief    : Directed bench driving one latency-1 and one latency-2 arbiter
//            in lockstep, each attached to its own SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_img_sram_arbiter;
  import img_sram_arb_pkg::*;

  localparam int ADDR_W = ROW_W + COL_W;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct {
    int               due;
    logic             client;
    logic [DATA_W-1:0] data;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] req;
  logic [DATA_W-1:0] c0_din, c1_din;
  logic [ROW_W-1:0]  c0_row, c1_row;
  logic [COL_W-1:0]  c0_col, c1_col;
  logic c0_we, c0_se, c1_we, c1_se;

  logic [1:0]        gnt_a, gnt_b;
  logic              busy_a, busy_b;
  logic [DATA_W-1:0] c0_dout_a, c1_dout_a, c0_dout_b, c1_dout_b;
  logic [DATA_W-1:0] sdin_a, sdin_b, sdout_a, sdout_b;
  logic [ROW_W-1:0]  srow_a, srow_b;
  logic [COL_W-1:0]  scol_a, scol_b;
  logic              swe_a, swe_b, sse_a, sse_b;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] rd1_a, rd1_b, rd2_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  sb_t q_a[$];
  sb_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  img_sram_arbiter #(.TURNAROUND(1), .DOUT_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_a), .busy(busy_a),
    .c0_din(c0_din), .c0_row(c0_row), .c0_col(c0_col), .c0_write_en(c0_we),
    .c0_sense_en(c0_se), .c0_dout(c0_dout_a),
    .c1_din(c1_din), .c1_row(c1_row), .c1_col(c1_col), .c1_write_en(c1_we),
    .c1_sense_en(c1_se), .c1_dout(c1_dout_a),
    .sram_din(sdin_a), .sram_row(srow_a), .sram_col(scol_a),
    .sram_write_en(swe_a), .sram_sense_en(sse_a), .sram_dout(sdout_a)
  );

  img_sram_arbiter #(.TURNAROUND(1), .DOUT_LAT(2)) u_dut_b (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_b), .busy(busy_b),
    .c0_din(c0_din), .c0_row(c0_row), .c0_col(c0_col), .c0_write_en(c0_we),
    .c0_sense_en(c0_se), .c0_dout(c0_dout_b),
    .c1_din(c1_din), .c1_row(c1_row), .c1_col(c1_col), .c1_write_en(c1_we),
    .c1_sense_en(c1_se), .c1_dout(c1_dout_b),
    .sram_din(sdin_b), .sram_row(srow_b), .sram_col(scol_b),
    .sram_write_en(swe_b), .sram_sense_en(sse_b), .sram_dout(sdout_b)
  );

  // SRAM models: synchronous write, read data registered DOUT_LAT times.
  always @(posedge clk) begin
    if (swe_a) mem_a[{srow_a, scol_a}] <= sdin_a;
    rd1_a <= mem_a[{srow_a, scol_a}];
    if (swe_b) mem_b[{srow_b, scol_b}] <= sdin_b;
    rd1_b <= mem_b[{srow_b, scol_b}];
    rd2_b <= rd1_b;
  end
  assign sdout_a = rd1_a;
  assign sdout_b = rd2_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_clients();
    c0_din = '0; c0_row = '0; c0_col = '0; c0_we = 1'b0; c0_se = 1'b1;
    c1_din = '0; c1_row = '0; c1_col = '0; c1_we = 1'b0; c1_se = 1'b1;
  endtask

  task automatic drive(input logic client, input logic we, input logic se,
                       input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col,
                       input logic [DATA_W-1:0] din);
    if (client) begin
      c1_we = we; c1_se = se; c1_row = row; c1_col = col; c1_din = din;
    end else begin
      c0_we = we; c0_se = se; c0_row = row; c0_col = col; c0_din = din;
    end
  endtask

  task automatic push_read(input logic client, input logic [ROW_W-1:0] row,
                           input logic [COL_W-1:0] col);
    q_a.push_back('{due: cyc + 1, client: client, data: ref_mem[{row, col}]});
    q_b.push_back('{due: cyc + 2, client: client, data: ref_mem[{row, col}]});
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt_a"},  gnt_a,  2'b00);
    chk({tag, "_gnt_b"},  gnt_b,  2'b00);
    chk({tag, "_busy_a"}, busy_a, 1'b0);
    chk({tag, "_busy_b"}, busy_b, 1'b0);
    chk({tag, "_hold_a"}, {sdin_a, srow_a, scol_a, swe_a, sse_a}, {16'h0, 2'b01});
    chk({tag, "_hold_b"}, {sdin_b, srow_b, scol_b, swe_b, sse_b}, {16'h0, 2'b01});
    chk({tag, "_dout_a"}, {c0_dout_a, c1_dout_a}, 16'h0);
    chk({tag, "_dout_b"}, {c0_dout_b, c1_dout_b}, 16'h0);
  endtask

  // Scoreboard: compare routed read data on the cycle it is due.
  always @(negedge clk) begin : sb_mon
    sb_t e;
    if (!rst) begin
      while (q_a.size() > 0 && q_a[0].due <= cyc) begin
        e = q_a.pop_front();
        chk("a_dout_owner", e.client ? c1_dout_a : c0_dout_a, e.data);
        chk("a_dout_other", e.client ? c0_dout_a : c1_dout_a, 0);
      end
      while (q_b.size() > 0 && q_b[0].due <= cyc) begin
        e = q_b.pop_front();
        chk("b_dout_owner", e.client ? c1_dout_b : c0_dout_b, e.data);
        chk("b_dout_other", e.client ? c0_dout_b : c1_dout_b, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic owner;
    logic other;
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = '0; mem_b[i] = '0; ref_mem[i] = '0;
    end
    rd1_a = '0; rd1_b = '0; rd2_b = '0;
    rst = 1'b1; req = 2'b00;
    idle_clients();
    repeat (3) step();
    chk_quiet("reset");
    rst = 1'b0;
    step();

    // Single client write then read-back, with c1 attempting writes meanwhile
    req = 2'b01;
    step();
    chk("t1_gnt_a", gnt_a, 2'b01);
    chk("t1_gnt_b", gnt_b, 2'b01);
    chk("t1_busy", {busy_a, busy_b}, 2'b11);
    drive(1'b0, 1'b1, 1'b1, 2'd3, 6'd7, 8'hA5);
    drive(1'b1, 1'b1, 1'b1, 2'd3, 6'd7, 8'hFF);
    ref_mem[{2'd3, 6'd7}] = 8'hA5;
    #1;
    chk("t1_pass_a", {sdin_a, swe_a}, {8'hA5, 1'b1});
    chk("t1_pass_b", {sdin_b, swe_b}, {8'hA5, 1'b1});
    step();
    drive(1'b0, 1'b0, 1'b0, 2'd3, 6'd7, 8'h00);
    push_read(1'b0, 2'd3, 6'd7);
    step();
    drive(1'b0, 1'b0, 1'b1, 2'd0, 6'd0, 8'h00);
    drive(1'b1, 1'b0, 1'b1, 2'd0, 6'd0, 8'h00);
    step();
    drive(1'b0, 1'b0, 1'b0, 2'd3, 6'd7, 8'h00);
    push_read(1'b0, 2'd3, 6'd7);
    step();
    idle_clients();
    req = 2'b00;
    step();
    chk("t1_release_gnt", {gnt_a, gnt_b}, 4'b0000);
    step();
    step();
    chk("t1_drained", {busy_a, busy_b}, 2'b00);

    // Simultaneous request after reset; read in the last owned cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    req = 2'b11;
    step();
    chk("t2_tie_a", gnt_a, 2'b01);
    chk("t2_tie_b", gnt_b, 2'b01);
    drive(1'b0, 1'b0, 1'b0, 2'd3, 6'd7, 8'h00);
    push_read(1'b0, 2'd3, 6'd7);
    req = 2'b10;
    #1;
    chk("t2_last_read_se", {sse_a, sse_b}, 2'b00);
    step();
    idle_clients();
    #1;
    chk("t2_turn_gnt", {gnt_a, gnt_b}, 4'b0000);
    chk("t2_turn_hold_a", {sdin_a, srow_a, scol_a, swe_a, sse_a}, {16'h0, 2'b01});
    chk("t2_turn_busy", {busy_a, busy_b}, 2'b11);
    step();
    chk("t2_c1_gnt_a", gnt_a, 2'b10);
    chk("t2_c1_gnt_b", gnt_b, 2'b10);
    drive(1'b1, 1'b1, 1'b1, 2'd1, 6'd20, 8'h3C);
    ref_mem[{2'd1, 6'd20}] = 8'h3C;
    step();
    drive(1'b1, 1'b0, 1'b0, 2'd1, 6'd20, 8'h00);
    push_read(1'b1, 2'd1, 6'd20);
    step();
    idle_clients();
    step();

    // Round robin across four handoffs, both clients re-requesting
    owner = 1'b1;
    for (int h = 0; h < 4; h++) begin
      other = ~owner;
      req = other ? 2'b10 : 2'b01;
      step();
      chk("t5_turn_gnt", gnt_a, 2'b00);
      req = 2'b11;
      step();
      chk("t5_rr_gnt_a", gnt_a, other ? 2'b10 : 2'b01);
      chk("t5_rr_gnt_b", gnt_b, other ? 2'b10 : 2'b01);
      owner = other;
    end

    // Reset while c1 owns with a read in flight
    drive(1'b1, 1'b0, 1'b0, 2'd3, 6'd7, 8'h00);
    step();
    chk("t6_c1_read_a", c1_dout_a, ref_mem[{2'd3, 6'd7}]);
    rst = 1'b1;
    #1;
    chk_quiet("t6_async");
    step();
    chk_quiet("t6_held");
    rst = 1'b0;
    idle_clients();
    step();
    chk("t6_tie_a", gnt_a, 2'b01);
    chk("t6_tie_b", gnt_b, 2'b01);

    req = 2'b00;
    repeat (4) step();
    chk("sb_empty_a", q_a.size(), 0);
    chk("sb_empty_b", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
